// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: state encoding and default sizes for the register-file dump engine.
package regfile_dump_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks an inclusive, wrapping register index range and streams each sampled value with its index.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [ADDR_W-1:0] cur_idx, end_idx, nxt_idx;
  assign nxt_idx = (cur_idx == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_idx + 1'b1;
  assign busy = (state == READ) || (state == HOLD);
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cur_idx   <= '0;
      end_idx   <= '0;
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (abort) begin
      // Beat payload is left intact so a debugger can still see where the dump stopped.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            end_idx <= last_idx;
            cur_idx <= first_idx;
            rf_addr <= first_idx;
            state   <= READ;
          end
        READ: begin
          out_data  <= rf_data;
          out_idx   <= cur_idx;
          out_last  <= cur_idx == end_idx;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD:
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) state <= DONE;
            else begin
              cur_idx <= nxt_idx;
              rf_addr <= nxt_idx;
              state   <= READ;
            end
          end
        DONE: state <= IDLE;
      endcase
endmodule
